mprj_bram_arbiter: RTL and testbench

- Shares the single-port user-project BRAM (mprjram, 0x38000000 window) between NUM_REQ masters: req 0 is the Wishbone CPU path; reqs 1..3 are the FIR engine, the matmul engine and the UART RX buffer.
- Round-robin arbitration with burst locking, one BRAM access per cycle, and a pipelined read-response return matched to BRAM latency.
- Sits between the requester ports and the BRAM macro inside user_proj_example.

---
 rtl/mprj_arb_pkg.sv | 28 ++
 rtl/mprj_bram_arbiter_rr.sv | 46 ++++
 rtl/mprj_bram_arbiter.sv | 175 +++++++++++++++++
 tb/tb_mprj_bram_arbiter.sv | 357 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mprj_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mprj_arb_pkg
// Description : Shared definitions for the user-project BRAM arbiter.
//               Requester IDs, the ID-width helper and the arbiter FSM state
//               type.
// Revision    : 1.0 - initial release
// ============================================================================
package mprj_arb_pkg;

  // Fixed requester slots on the mprjram port
  localparam int CPU  = 0;  // Wishbone CPU path
  localparam int FIR  = 1;  // FIR engine
  localparam int MM   = 2;  // matmul engine
  localparam int UART = 3;  // UART RX buffer

  // Width of a binary requester index; never narrower than one bit
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/mprj_bram_arbiter_rr.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational circular-priority picker. Scans the request
//               vector starting at ptr and wrapping, and returns the first
//               requester found.
// Ports       : req   - request vector
//               ptr   - index with highest priority this cycle
//               grant - one-hot winner (zero when no request)
//               idx   - binary winner index (0 when no request)
//               any   - at least one request present
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
  parameter int N    = 4,
  parameter int ID_W = 2
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] ptr,
  output logic [N-1:0]    grant,
  output logic [ID_W-1:0] idx,
  output logic            any
);

  always_comb begin
    int            pos;
    logic [ID_W-1:0] pos_idx;
    grant   = '0;
    idx     = '0;
    any     = 1'b0;
    pos     = 0;
    pos_idx = '0;
    for (int i = 0; i < N; i++) begin
      pos = int'(ptr) + i;
      if (pos >= N) pos = pos - N;
      pos_idx = ID_W'(pos);
      if (!any && req[pos_idx]) begin
        any            = 1'b1;
        grant[pos_idx] = 1'b1;
        idx            = pos_idx;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/mprj_bram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mprj_bram_arbiter
// Description : Shares the single-port mprjram BRAM between NUM_REQ masters
//               (0 = Wishbone CPU, 1 = FIR, 2 = matmul, 3 = UART RX).
//               Round-robin arbitration with burst locking, one access per
//               cycle, and a BRAM_LAT-deep read-response pipeline.
// Option      : MPRJ_ARB_CPU_PRIORITY_EN - when defined, requester 0 wins
//               every IDLE arbitration it takes part in; locked bursts are
//               never preempted.
// Ports       : wb_clk_i/wb_rst_i      - clock, sync active-high reset
//               req_valid/we/last      - per-requester beat control
//               req_addr/wdata/wstrb   - packed per-requester beat payload
//               req_ready              - beat accepted this cycle (one-hot)
//               rsp_valid/rsp_rdata    - read response, BRAM_LAT after accept
//               bram_en/we/addr/wdata  - BRAM macro drive
//               bram_rdata             - BRAM read data
//               grant_id               - current or most recent owner
// Revision    : 1.0 - initial release
// ============================================================================
module mprj_bram_arbiter
  import mprj_arb_pkg::*;
#(
  parameter  int NUM_REQ  = 4,
  parameter  int ADDR_W   = 12,
  parameter  int DATA_W   = 32,
  parameter  int BRAM_LAT = 2,
  localparam int ID_W     = id_width(NUM_REQ),
  localparam int STRB_W   = DATA_W / 8
) (
  input  logic                       wb_clk_i,
  input  logic                       wb_rst_i,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ-1:0]         req_we,
  input  logic [NUM_REQ-1:0]         req_last,
  input  logic [NUM_REQ*ADDR_W-1:0]  req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]  req_wdata,
  input  logic [NUM_REQ*STRB_W-1:0]  req_wstrb,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic [NUM_REQ-1:0]         rsp_valid,
  output logic [DATA_W-1:0]          rsp_rdata,
  output logic                       bram_en,
  output logic [STRB_W-1:0]          bram_we,
  output logic [ADDR_W-1:0]          bram_addr,
  output logic [DATA_W-1:0]          bram_wdata,
  input  logic [DATA_W-1:0]          bram_rdata,
  output logic [ID_W-1:0]            grant_id
);

  // Response pipeline entry is {valid, id}
  localparam int ENT_W  = 1 + ID_W;
  localparam int PIPE_W = BRAM_LAT * ENT_W;

  arb_state_t        r_state, w_state_nxt;
  logic [ID_W-1:0]   r_rr_ptr, w_rr_ptr_nxt;
  logic [ID_W-1:0]   r_owner, w_owner_nxt;
  logic [ID_W-1:0]   r_grant_id;
  logic [PIPE_W-1:0] r_pipe;

  logic [NUM_REQ-1:0] w_rr_grant;
  logic [ID_W-1:0]    w_rr_idx;
  logic               w_rr_any;

  logic               w_accept;
  logic [ID_W-1:0]    w_win;
  logic [NUM_REQ-1:0] w_win_oh;
  logic [ENT_W-1:0]   w_pipe_in;
  logic [ENT_W-1:0]   w_pipe_out;

  logic [ADDR_W-1:0] w_addr_arr  [NUM_REQ];
  logic [DATA_W-1:0] w_wdata_arr [NUM_REQ];
  logic [STRB_W-1:0] w_wstrb_arr [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign w_addr_arr[gi]  = req_addr[gi*ADDR_W +: ADDR_W];
    assign w_wdata_arr[gi] = req_wdata[gi*DATA_W +: DATA_W];
    assign w_wstrb_arr[gi] = req_wstrb[gi*STRB_W +: STRB_W];
  end

  rr_arbiter #(
    .N    (NUM_REQ),
    .ID_W (ID_W)
  ) u_rr (
    .req   (req_valid),
    .ptr   (r_rr_ptr),
    .grant (w_rr_grant),
    .idx   (w_rr_idx),
    .any   (w_rr_any)
  );

  // Next-state / accept decision. Everything is gated by reset so the
  // combinational outputs read as zero while reset is held.
  always_comb begin
    w_state_nxt  = r_state;
    w_owner_nxt  = r_owner;
    w_rr_ptr_nxt = r_rr_ptr;
    w_accept     = 1'b0;
    w_win        = r_owner;
    w_win_oh     = '0;

    if (!wb_rst_i) begin
      case (r_state)
        IDLE: begin
          if (w_rr_any) begin
            w_accept = 1'b1;
            w_win    = w_rr_idx;
            w_win_oh = w_rr_grant;
`ifdef MPRJ_ARB_CPU_PRIORITY_EN
            if (req_valid[CPU]) begin
              w_win    = ID_W'(CPU);
              w_win_oh = NUM_REQ'(1) << CPU;
            end
`endif
          end
        end
        LOCKED: begin
          // Only the owner may proceed; an owner stall leaves the BRAM idle
          if (req_valid[r_owner]) begin
            w_accept = 1'b1;
            w_win    = r_owner;
            w_win_oh = NUM_REQ'(1) << r_owner;
          end
        end
        default: w_state_nxt = IDLE;
      endcase

      if (w_accept) begin
        if (req_last[w_win]) begin
          w_state_nxt  = IDLE;
          w_rr_ptr_nxt = (w_win == ID_W'(NUM_REQ - 1)) ? '0 : w_win + ID_W'(1);
`ifdef MPRJ_ARB_CPU_PRIORITY_EN
          // CPU wins by priority, so its grants do not rotate fairness
          if (w_win == ID_W'(CPU)) w_rr_ptr_nxt = r_rr_ptr;
`endif
        end else begin
          w_state_nxt = LOCKED;
          w_owner_nxt = w_win;
        end
      end
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state    <= IDLE;
      r_rr_ptr   <= '0;
      r_owner    <= '0;
      r_grant_id <= '0;
      r_pipe     <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_rr_ptr <= w_rr_ptr_nxt;
      r_owner  <= w_owner_nxt;
      if (w_accept) r_grant_id <= w_win;
      // Newest entry enters at the bottom; oldest falls off the top
      r_pipe <= PIPE_W'({r_pipe, w_pipe_in});
    end
  end

  assign w_pipe_in  = {w_accept & ~req_we[w_win], w_win};
  assign w_pipe_out = r_pipe[PIPE_W-1 -: ENT_W];

  assign req_ready  = w_win_oh;
  assign bram_en    = w_accept;
  assign bram_we    = (w_accept && req_we[w_win]) ? w_wstrb_arr[w_win] : '0;
  assign bram_addr  = w_accept ? w_addr_arr[w_win]  : '0;
  assign bram_wdata = w_accept ? w_wdata_arr[w_win] : '0;
  assign grant_id   = wb_rst_i ? '0 : (w_accept ? w_win : r_grant_id);

  assign rsp_valid = (!wb_rst_i && w_pipe_out[ENT_W-1])
                     ? (NUM_REQ'(1) << w_pipe_out[ID_W-1:0]) : '0;
  assign rsp_rdata = (!wb_rst_i && w_pipe_out[ENT_W-1]) ? bram_rdata : '0;

endmodule
`default_nettype wire

// File: tb/tb_mprj_bram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mprj_bram_arbiter
// Description : Self-checking bench for mprj_bram_arbiter with a 2-cycle
//               BRAM model, directed scenarios and a randomized run checked
//               against a transaction-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mprj_bram_arbiter;

  localparam int N  = 4;
  localparam int AW = 12;
  localparam int DW = 32;
  localparam int SW = 4;
  localparam int IW = 2;

  logic clk = 1'b0;
  logic rst;
  logic [N-1:0]    req_valid, req_we, req_last, req_ready, rsp_valid;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [N*SW-1:0] req_wstrb;
  logic [DW-1:0]   rsp_rdata, bram_wdata, bram_rdata;
  logic            bram_en;
  logic [SW-1:0]   bram_we;
  logic [AW-1:0]   bram_addr;
  logic [IW-1:0]   grant_id;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mprj_bram_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .BRAM_LAT(2)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .req_valid(req_valid), .req_we(req_we), .req_last(req_last),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .bram_en(bram_en), .bram_we(bram_we), .bram_addr(bram_addr),
    .bram_wdata(bram_wdata), .bram_rdata(bram_rdata), .grant_id(grant_id)
  );

  function automatic logic [31:0] init_word(input logic [11:0] a);
    return (a == 12'h010) ? 32'hDEADBEEF : {20'h5EED0, a};
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (s[b]) r[b*8 +: 8] = d[b*8 +: 8];
    return r;
  endfunction

  // BRAM model: read-first, data valid two cycles after the enable cycle
  logic [DW-1:0] bmem [4096];
  bit            bwr  [4096];
  logic [DW-1:0] rd_q1;
  logic [DW-1:0] bcur;
  always @(posedge clk) begin
    if (bram_en) begin
      bcur = bwr[bram_addr] ? bmem[bram_addr] : init_word(bram_addr);
      rd_q1 <= bcur;
      if (bram_we != 4'h0) begin
        bmem[bram_addr] <= merge(bcur, bram_wdata, bram_we);
        bwr[bram_addr]  <= 1'b1;
      end
    end
    bram_rdata <= rd_q1;
  end

  // Shadow memory for the reference model
  logic [DW-1:0] smem [4096];
  bit            swr  [4096];

  task automatic clr();
    req_valid = '0; req_we = '0; req_last = '0;
    req_addr = '0; req_wdata = '0; req_wstrb = '0;
  endtask

  task automatic set_req(input int i, input logic we, input logic last, input logic [11:0] a,
                         input logic [31:0] d, input logic [3:0] s);
    req_valid[i] = 1'b1; req_we[i] = we; req_last[i] = last;
    req_addr[i*AW +: AW] = a; req_wdata[i*DW +: DW] = d; req_wstrb[i*SW +: SW] = s;
  endtask

  task automatic do_reset();
    rst = 1'b1; clr();
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < N; i++) set_req(i, 1'b1, 1'b0, 12'h0AB, 32'h12345678, 4'hF);
    for (int k = 0; k < 2; k++) begin
      #1;
      n_chk++; if (req_ready !== 4'h0) begin n_fail++; $display("FAIL reset req_ready got %b want 0000", req_ready); end
      n_chk++; if (rsp_valid !== 4'h0) begin n_fail++; $display("FAIL reset rsp_valid got %b want 0000", rsp_valid); end
      n_chk++; if (bram_en !== 1'b0) begin n_fail++; $display("FAIL reset bram_en got %b want 0", bram_en); end
      n_chk++; if (bram_we !== 4'h0) begin n_fail++; $display("FAIL reset bram_we got %h want 0", bram_we); end
      n_chk++; if (bram_addr !== 12'h0) begin n_fail++; $display("FAIL reset bram_addr got %h want 0", bram_addr); end
      n_chk++; if (bram_wdata !== 32'h0) begin n_fail++; $display("FAIL reset bram_wdata got %h want 0", bram_wdata); end
      n_chk++; if (rsp_rdata !== 32'h0) begin n_fail++; $display("FAIL reset rsp_rdata got %h want 0", rsp_rdata); end
      n_chk++; if (grant_id !== 2'd0) begin n_fail++; $display("FAIL reset grant_id got %0d want 0", grant_id); end
      @(negedge clk);
    end
    rst = 1'b0; clr();
  endtask

  task automatic test_single_read();
    do_reset();
    for (int k = 0; k < 4; k++) begin
      clr();
      if (k == 0) set_req(1, 1'b0, 1'b1, 12'h010, 32'h0, 4'h0);
      #1;
      if (k == 0) begin
        n_chk++; if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL single_read ready got %b want 0010", req_ready); end
        n_chk++; if (bram_addr !== 12'h010 || bram_en !== 1'b1) begin n_fail++; $display("FAIL single_read bram got en=%b addr=%h want en=1 addr=010", bram_en, bram_addr); end
        n_chk++; if (grant_id !== 2'd1) begin n_fail++; $display("FAIL single_read grant_id got %0d want 1", grant_id); end
      end else if (k == 2) begin
        n_chk++; if (rsp_valid !== 4'b0010 || rsp_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL single_read rsp got v=%b d=%h want v=0010 d=deadbeef", rsp_valid, rsp_rdata); end
      end else begin
        n_chk++; if (rsp_valid !== 4'b0000) begin n_fail++; $display("FAIL single_read idle_rsp cycle %0d got %b want 0000", k, rsp_valid); end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_round_robin();
    int g, r;
    do_reset();
    for (int k = 0; k < 10; k++) begin
      clr();
      if (k < 8) for (int i = 0; i < N; i++) set_req(i, 1'b0, 1'b1, 12'(12'h020 + i), 32'h0, 4'h0);
      #1;
      if (k < 8) begin
        g = k % 4;
        n_chk++; if (req_ready !== (4'b0001 << g)) begin n_fail++; $display("FAIL rr ready cycle %0d got %b want %b", k, req_ready, 4'b0001 << g); end
        n_chk++; if (grant_id !== IW'(g) || bram_addr !== 12'(12'h020 + g)) begin n_fail++; $display("FAIL rr grant cycle %0d got id=%0d addr=%h want id=%0d", k, grant_id, bram_addr, g); end
      end
      if (k >= 2) begin
        r = (k - 2) % 4;
        n_chk++; if (rsp_valid !== (4'b0001 << r) || rsp_rdata !== init_word(12'(12'h020 + r))) begin n_fail++; $display("FAIL rr rsp cycle %0d got v=%b d=%h want v=%b d=%h", k, rsp_valid, rsp_rdata, 4'b0001 << r, init_word(12'(12'h020 + r))); end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_burst_lock();
    logic [3:0]  stt [4];
    logic [31:0] expw [4];
    logic [31:0] d;
    stt[0] = 4'hF; stt[1] = 4'h3; stt[2] = 4'hC; stt[3] = 4'h0;
    do_reset();
    for (int k = 0; k < 7; k++) begin
      clr();
      if (k < 4) begin
        d = 32'h11111111 * (k + 1);
        expw[k] = merge(init_word(12'(12'h100 + k)), d, stt[k]);
        set_req(2, 1'b1, (k == 3), 12'(12'h100 + k), d, stt[k]);
      end
      if (k >= 1 && k <= 4) set_req(0, 1'b0, 1'b1, 12'h030, 32'h0, 4'h0);
      #1;
      if (k < 4) begin
        n_chk++; if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL burst ready beat %0d got %b want 0100", k, req_ready); end
        n_chk++; if (bram_we !== stt[k] || bram_addr !== 12'(12'h100 + k)) begin n_fail++; $display("FAIL burst bram beat %0d got we=%h addr=%h want we=%h", k, bram_we, bram_addr, stt[k]); end
      end
      if (k == 4) begin
        n_chk++; if (req_ready !== 4'b0001 || grant_id !== 2'd0) begin n_fail++; $display("FAIL burst cpu_after got ready=%b id=%0d want 0001/0", req_ready, grant_id); end
      end
      if (k < 6) begin
        n_chk++; if (rsp_valid !== 4'h0) begin n_fail++; $display("FAIL burst no_rsp cycle %0d got %b want 0000", k, rsp_valid); end
      end else begin
        n_chk++; if (rsp_valid !== 4'b0001 || rsp_rdata !== init_word(12'h030)) begin n_fail++; $display("FAIL burst cpu_rsp got v=%b d=%h want 0001/%h", rsp_valid, rsp_rdata, init_word(12'h030)); end
      end
      @(negedge clk);
    end
    // Read the burst back through the FIR port
    for (int k = 0; k < 6; k++) begin
      clr();
      if (k < 4) set_req(1, 1'b0, 1'b1, 12'(12'h100 + k), 32'h0, 4'h0);
      #1;
      if (k >= 2) begin
        n_chk++; if (rsp_valid !== 4'b0010 || rsp_rdata !== expw[k-2]) begin n_fail++; $display("FAIL burst readback word %0d got v=%b d=%h want 0010/%h", k - 2, rsp_valid, rsp_rdata, expw[k-2]); end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_owner_stall();
    do_reset();
    for (int k = 0; k < 6; k++) begin
      clr();
      if (k == 0) set_req(3, 1'b1, 1'b0, 12'h200, 32'hCAFE0000, 4'hF);
      if (k == 4) set_req(3, 1'b1, 1'b1, 12'h201, 32'hCAFE0001, 4'hF);
      if (k >= 1) set_req(1, 1'b0, 1'b1, 12'h050, 32'h0, 4'h0);
      #1;
      if (k == 0 || k == 4) begin
        n_chk++; if (req_ready !== 4'b1000 || bram_en !== 1'b1) begin n_fail++; $display("FAIL stall owner_beat cycle %0d got ready=%b en=%b want 1000/1", k, req_ready, bram_en); end
      end else if (k == 5) begin
        n_chk++; if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL stall next_winner got %b want 0010", req_ready); end
      end else begin
        n_chk++; if (req_ready !== 4'h0 || bram_en !== 1'b0 || grant_id !== 2'd3) begin n_fail++; $display("FAIL stall hold cycle %0d got ready=%b en=%b id=%0d want 0000/0/3", k, req_ready, bram_en, grant_id); end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_midflight();
    do_reset();
    set_req(2, 1'b0, 1'b1, 12'h040, 32'h0, 4'h0);
    #1;
    n_chk++; if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL midrst accept got %b want 0100", req_ready); end
    @(negedge clk);
    rst = 1'b1; clr();
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_chk++; if (rsp_valid !== 4'h0 || rsp_rdata !== 32'h0) begin n_fail++; $display("FAIL midrst stale_rsp cycle %0d got v=%b d=%h want 0", k, rsp_valid, rsp_rdata); end
      n_chk++; if (grant_id !== 2'd0 || bram_en !== 1'b0 || bram_addr !== 12'h0) begin n_fail++; $display("FAIL midrst outputs cycle %0d got id=%0d en=%b addr=%h want 0", k, grant_id, bram_en, bram_addr); end
      @(negedge clk);
    end
    for (int i = 0; i < N; i++) set_req(i, 1'b0, 1'b1, 12'h060, 32'h0, 4'h0);
    #1;
    n_chk++; if (req_ready !== 4'b0001 || grant_id !== 2'd0) begin n_fail++; $display("FAIL midrst first_grant got ready=%b id=%0d want 0001/0", req_ready, grant_id); end
    @(negedge clk);
    clr();
  endtask

  task automatic test_priority();
    logic [3:0] exp_rdy;
    do_reset();
    set_req(1, 1'b0, 1'b1, 12'h070, 32'h0, 4'h0);
    #1;
    n_chk++; if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL prio setup got %b want 0010", req_ready); end
    @(negedge clk);
    for (int k = 1; k <= 4; k++) begin
      clr();
      set_req(0, 1'b0, 1'b1, 12'h071, 32'h0, 4'h0);
      set_req(2, 1'b0, 1'b1, 12'h072, 32'h0, 4'h0);
`ifdef MPRJ_ARB_CPU_PRIORITY_EN
      exp_rdy = 4'b0001;
`else
      exp_rdy = (k % 2 == 1) ? 4'b0100 : 4'b0001;
`endif
      #1;
      n_chk++; if (req_ready !== exp_rdy) begin n_fail++; $display("FAIL prio cycle %0d got %b want %b", k, req_ready, exp_rdy); end
      @(negedge clk);
    end
    clr();
  endtask

  typedef struct { int due; int id; logic [31:0] data; } rsp_t;

  task automatic test_random();
    bit   pend [N];
    int   left [N];
    rsp_t q [$];
    rsp_t e;
    int   mptr, mown, mgid, w, a;
    bit   mlock;
    logic [3:0] exp_we;
    mptr = 0; mown = 0; mgid = 0; mlock = 0;
    for (int i = 0; i < N; i++) begin pend[i] = 0; left[i] = 0; end
    do_reset();
    for (int c = 0; c < 403; c++) begin
      if (c >= 400) begin
        clr();
        for (int i = 0; i < N; i++) pend[i] = 0;
      end else begin
        for (int i = 0; i < N; i++) begin
          if (!pend[i]) begin
            req_valid[i] = 1'b0;
            if (left[i] == 0 && $urandom_range(0, 2) == 0) left[i] = $urandom_range(1, 4);
            if (left[i] > 0 && $urandom_range(0, 3) != 0) begin
              pend[i] = 1;
              set_req(i, 1'($urandom_range(0, 1)), (left[i] == 1), 12'($urandom_range(0, 31)),
                      $urandom, 4'($urandom_range(0, 15)));
            end
          end
        end
      end
      // Expected winner from the arbitration rules
      w = -1;
      if (mlock) begin
        if (req_valid[mown]) w = mown;
      end else begin
`ifdef MPRJ_ARB_CPU_PRIORITY_EN
        if (req_valid[0]) w = 0;
`endif
        for (int k = 0; k < N && w < 0; k++) if (req_valid[(mptr + k) % N]) w = (mptr + k) % N;
      end
      #1;
      n_chk++; if (req_ready !== ((w >= 0) ? (4'b0001 << w) : 4'b0000) || bram_en !== (w >= 0)) begin n_fail++; $display("FAIL rand accept cycle %0d got ready=%b en=%b want winner %0d", c, req_ready, bram_en, w); end
      if (w >= 0) begin
        exp_we = req_we[w] ? req_wstrb[w*SW +: SW] : 4'h0;
        n_chk++; if (bram_addr !== req_addr[w*AW +: AW] || bram_we !== exp_we || bram_wdata !== req_wdata[w*DW +: DW]) begin n_fail++; $display("FAIL rand bram cycle %0d got addr=%h we=%h wd=%h want addr=%h we=%h wd=%h", c, bram_addr, bram_we, bram_wdata, req_addr[w*AW +: AW], exp_we, req_wdata[w*DW +: DW]); end
        n_chk++; if (grant_id !== IW'(w)) begin n_fail++; $display("FAIL rand grant_id cycle %0d got %0d want %0d", c, grant_id, w); end
      end else begin
        n_chk++; if (grant_id !== IW'(mgid)) begin n_fail++; $display("FAIL rand grant_hold cycle %0d got %0d want %0d", c, grant_id, mgid); end
      end
      if (q.size() > 0 && q[0].due == c) begin
        e = q.pop_front();
        n_chk++; if (rsp_valid !== (4'b0001 << e.id) || rsp_rdata !== e.data) begin n_fail++; $display("FAIL rand rsp cycle %0d got v=%b d=%h want v=%b d=%h", c, rsp_valid, rsp_rdata, 4'b0001 << e.id, e.data); end
      end else begin
        n_chk++; if (rsp_valid !== 4'h0) begin n_fail++; $display("FAIL rand no_rsp cycle %0d got %b want 0000", c, rsp_valid); end
      end
      // Model update for the accepted beat
      if (w >= 0) begin
        pend[w] = 0;
        left[w] = left[w] - 1;
        a = int'(req_addr[w*AW +: AW]);
        if (req_we[w]) begin
          smem[a] = merge(swr[a] ? smem[a] : init_word(12'(a)), req_wdata[w*DW +: DW], req_wstrb[w*SW +: SW]);
          swr[a]  = 1;
        end else begin
          e.due = c + 2; e.id = w; e.data = swr[a] ? smem[a] : init_word(12'(a));
          q.push_back(e);
        end
        mgid = w;
        if (req_last[w]) begin
          mlock = 0;
`ifdef MPRJ_ARB_CPU_PRIORITY_EN
          if (w != 0) mptr = (w + 1) % N;
`else
          mptr = (w + 1) % N;
`endif
        end else begin
          mlock = 1;
          mown  = w;
        end
      end
      @(negedge clk);
    end
    n_chk++; if (q.size() != 0) begin n_fail++; $display("FAIL rand drain got %0d pending responses want 0", q.size()); end
  endtask

  initial begin
    rst = 1'b1;
    clr();
    @(negedge clk);
    test_reset();
    test_single_read();
    test_round_robin();
    test_burst_lock();
    test_owner_stall();
    test_reset_midflight();
    test_priority();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
